// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready handshake from the boot/debug source into imem_loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    modport master(output in_valid, in_data, input in_ready);
    modport slave(input in_valid, in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream (high byte first) into words written sequentially into imem from address 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte that sets err on mismatch.
module imem_loader #(
    parameter int N = 16,
    parameter int R = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [R:0]   len,
    imem_loader_if.slave src,
    output logic         imem_we,
    output logic [R-1:0] imem_addr,
    output logic [N-1:0] imem_wdata,
    output logic         busy,
    output logic         done,
    output logic [R:0]   words_loaded,
    output logic         err
);
    typedef enum logic [2:0] {
        IDLE, GET_HI, GET_LO, WRITE, DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t LAST = CHK;
`else
    localparam state_t LAST = DONE;
`endif
    localparam logic [R:0] DEPTH = (R+1)'(2 ** R);
    state_t     state, state_d;
    logic [R:0] len_eff;
    logic [7:0] hi;
    logic       acc, go, last;
    logic [R:0] len_clamp;
    assign acc = src.in_valid && src.in_ready;
    assign go = start && (state == IDLE || state == DONE);
    assign len_clamp = len > DEPTH ? DEPTH : len;
    assign last = words_loaded + (R+1)'(1) == len_eff;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign src.in_ready = state == GET_HI || state == GET_LO || state == CHK;
`else
    assign src.in_ready = state == GET_HI || state == GET_LO;
`endif
    assign imem_we = state == WRITE;
    assign busy = !(state == IDLE || state == DONE);
    assign done = state == DONE;
    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: if (go) state_d = len_clamp == '0 ? DONE : GET_HI;
            GET_HI:     if (acc) state_d = GET_LO;
            GET_LO:     if (acc) state_d = WRITE;
            WRITE:      state_d = last ? LAST : GET_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:        if (acc) state_d = DONE;
`endif
            default:    state_d = IDLE;
        endcase
    end
    // words_loaded doubles as the next write address; imem_addr/wdata latch only when a word completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_eff      <= '0;
            hi           <= '0;
            words_loaded <= '0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
        end else begin
            state <= state_d;
            if (go) begin
                len_eff      <= len_clamp;
                words_loaded <= '0;
            end
            if (acc && state == GET_HI) hi <= src.in_data;
            if (acc && state == GET_LO) begin
                imem_wdata <= {hi, src.in_data};
                imem_addr  <= words_loaded[R-1:0];
            end
            if (state == WRITE) words_loaded <= words_loaded + (R+1)'(1);
        end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (go) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (acc && state == CHK) begin
            err <= src.in_data != csum;
        end else if (acc) begin
            csum <= csum ^ src.in_data;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule
